// File: rtl/memshare_sched_ctrl.sv
// memShare sequencer: accepts one allocation request, steps through N
// pipeline cycles of PIPE_CYCLE_LEN clocks each, then holds busy for a
// drain window before a one-cycle done pulse. Captures the RFMU isGtr
// flag once per sequence on the first clock of its pipeline cycle.
module memshare_sched_ctrl #(
  parameter int MAX_ALLOC_SEQ_NUM = 3,
  parameter int PIPE_CYCLE_LEN    = 4,
  parameter int DRAIN_LEN         = 2,
  parameter int NUM_W             = $clog2(MAX_ALLOC_SEQ_NUM + 2)
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [NUM_W-1:0]           alloc_seq_num_i,
  output logic                       start_ready_o,
  input  logic                       stall_i,
  input  logic                       abort_i,
  input  logic                       isGtr_i,
  output logic                       scu_memShare_busy_o,
  output logic                       pipeCycle_begin_o,
  output logic [NUM_W-1:0]           seq_idx_o,
  output logic [MAX_ALLOC_SEQ_NUM:0] isGtr_vec_o,
  output logic [NUM_W-1:0]           gtr_cnt_o,
  output logic                       done_o
);

  localparam int SEQ_CNT = MAX_ALLOC_SEQ_NUM + 1;
  localparam int CYC_W   = (PIPE_CYCLE_LEN > 1) ? $clog2(PIPE_CYCLE_LEN) : 1;
  localparam int DRN_W   = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(PIPE_CYCLE_LEN - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_LEN - 1);
  localparam logic [NUM_W-1:0] N_MAX    = NUM_W'(SEQ_CNT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [NUM_W-1:0]     numSeq;
  logic [NUM_W-1:0]     seqIdx;
  logic [NUM_W-1:0]     gtrCnt;
  logic [NUM_W-1:0]     reqNum;
  logic [CYC_W-1:0]     cycCnt;
  logic [DRN_W-1:0]     drainCnt;
  logic [SEQ_CNT-1:0]   isGtrVec;
  logic                 pipeBegin;
  logic                 lastSeq;

  // Request clamp and per-cycle decode of the pipeline-cycle start
  always_comb begin
    reqNum    = (alloc_seq_num_i > N_MAX) ? N_MAX : alloc_seq_num_i;
    pipeBegin = (state == RUN) && (cycCnt == '0) && !stall_i;
    lastSeq   = (seqIdx == numSeq - NUM_W'(1));
  end

  // Control FSM: request latch, cycle/sequence counters, drain, capture
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= IDLE;
      numSeq   <= '0;
      seqIdx   <= '0;
      gtrCnt   <= '0;
      cycCnt   <= '0;
      drainCnt <= '0;
      isGtrVec <= '0;
    end else begin
      case (state)
        IDLE: begin
          // abort is meaningless here; start always wins
          if (start_i) begin
            numSeq   <= reqNum;
            seqIdx   <= '0;
            gtrCnt   <= '0;
            cycCnt   <= '0;
            drainCnt <= '0;
            isGtrVec <= '0;
            state    <= (reqNum == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (abort_i) begin
            state <= IDLE;
          end else if (!stall_i) begin
            if (pipeBegin) begin
              for (int i = 0; i < SEQ_CNT; i++)
                if (seqIdx == NUM_W'(i)) isGtrVec[i] <= isGtr_i;
              if (isGtr_i) gtrCnt <= gtrCnt + NUM_W'(1);
            end
            if (cycCnt == CYC_LAST) begin
              cycCnt <= '0;
              // seqIdx parks on the final sequence for DRAIN/DONE
              if (lastSeq) begin
                state    <= DRAIN;
                drainCnt <= '0;
              end else begin
                seqIdx <= seqIdx + NUM_W'(1);
              end
            end else begin
              cycCnt <= cycCnt + CYC_W'(1);
            end
          end
        end
        DRAIN: begin
          if (abort_i)                  state <= IDLE;
          else if (drainCnt == DRN_LAST) state <= DONE;
          else                           drainCnt <= drainCnt + DRN_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready_o       = (state == IDLE);
  assign scu_memShare_busy_o = (state == RUN) || (state == DRAIN);
  assign pipeCycle_begin_o   = pipeBegin;
  assign done_o              = (state == DONE);
  assign seq_idx_o           = seqIdx;
  assign isGtr_vec_o         = isGtrVec;
  assign gtr_cnt_o           = gtrCnt;

endmodule

// File: tb/tb_memshare_sched_ctrl.sv
// Bench for memshare_sched_ctrl: nominal timing table, hand-written
// corner sequences (reset, stall, abort, clamp, capture) and a random
// run, all shadowed by an elapsed-time reference model.
module tb_memshare_sched_ctrl;
  localparam int P = 4;
  localparam int D = 2;
  localparam int NMAX = 4;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [2:0] alloc_seq_num_i = '0;
  logic       stall_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       isGtr_i = 1'b0;
  logic       start_ready_o, scu_memShare_busy_o, pipeCycle_begin_o, done_o;
  logic [2:0] seq_idx_o, gtr_cnt_o;
  logic [3:0] isGtr_vec_o;

  memshare_sched_ctrl #(
    .MAX_ALLOC_SEQ_NUM(3), .PIPE_CYCLE_LEN(P), .DRAIN_LEN(D), .NUM_W(3)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .start_i(start_i),
    .alloc_seq_num_i(alloc_seq_num_i), .start_ready_o(start_ready_o),
    .stall_i(stall_i), .abort_i(abort_i), .isGtr_i(isGtr_i),
    .scu_memShare_busy_o(scu_memShare_busy_o),
    .pipeCycle_begin_o(pipeCycle_begin_o), .seq_idx_o(seq_idx_o),
    .isGtr_vec_o(isGtr_vec_o), .gtr_cnt_o(gtr_cnt_o), .done_o(done_o)
  );

  always #5 sys_clk = ~sys_clk;

  int nChecks = 0;
  int nErrors = 0;
  bit chkOn = 1'b0;

  // reference model: one elapsed-time counter per request
  bit         mAct = 1'b0;
  int         mN = 0, mT = 0, mCnt = 0, mSeq = 0;
  logic [3:0] mVec = '0;

  // last sampled DUT outputs
  logic       oReady, oBusy, oBegin, oDone;
  logic [2:0] oSeq, oCnt;
  logic [3:0] oVec;

  typedef struct {
    bit         start;
    logic [2:0] n;
    bit         eReady, eBusy, eBegin, eDone;
  } vec_t;
  vec_t tbl[13];

  function automatic vec_t mk(bit s, logic [2:0] n, bit r, bit b, bit g, bit d);
    vec_t v;
    v.start = s; v.n = n; v.eReady = r; v.eBusy = b; v.eBegin = g; v.eDone = d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int total();
    return (mN == 0) ? 0 : mN * P + D;
  endfunction

  // one clock: drive, compare at negedge against the model, advance model
  task automatic step(input bit r, input bit s, input logic [2:0] n,
                      input bit st, input bit ab, input bit g);
    bit eReady, eBusy, eBegin, eDone;
    rst = r; start_i = s; alloc_seq_num_i = n; stall_i = st; abort_i = ab; isGtr_i = g;
    @(negedge sys_clk);
    oReady = start_ready_o; oBusy = scu_memShare_busy_o; oBegin = pipeCycle_begin_o;
    oDone = done_o; oSeq = seq_idx_o; oVec = isGtr_vec_o; oCnt = gtr_cnt_o;
    eReady = !mAct;
    eBusy  = mAct && (mT < total());
    eBegin = mAct && (mT < mN * P) && (mT % P == 0) && !st;
    eDone  = mAct && (mT == total());
    if (chkOn) begin
      chk("ready", 32'(oReady), 32'(eReady));
      chk("busy",  32'(oBusy),  32'(eBusy));
      chk("begin", 32'(oBegin), 32'(eBegin));
      chk("done",  32'(oDone),  32'(eDone));
      chk("seq",   32'(oSeq),   32'(mSeq));
      chk("vec",   32'(oVec),   32'(mVec));
      chk("cnt",   32'(oCnt),   32'(mCnt));
    end
    @(posedge sys_clk);
    if (r) begin
      mAct = 0; mT = 0; mVec = '0; mCnt = 0; mSeq = 0;
    end else if (!mAct) begin
      if (s) begin
        mN = (int'(n) > NMAX) ? NMAX : int'(n);
        mAct = 1; mT = 0; mVec = '0; mCnt = 0; mSeq = 0;
      end
    end else if (ab || mT == total()) begin
      mAct = 0;
    end else if (!(mT < mN * P && st)) begin
      if (eBegin) begin
        mVec[mT / P] = g;
        mCnt += int'(g);
      end
      mT++;
      mSeq = (mT < mN * P) ? mT / P : mN - 1;
    end
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 3'd0, 0, 0, 0);
  endtask

  initial begin
    int beginsInStall, busyCnt, doneAt, beginMask, doneSeen;
    #1;
    // reset with start held: first cycle unknown state, then checked
    step(1, 1, 3'd2, 0, 0, 0);
    chkOn = 1'b1;
    step(1, 1, 3'd2, 0, 0, 0);
    chk("rst_ready", 32'(oReady), 32'd1);
    chk("rst_busy",  32'(oBusy),  32'd0);
    step(0, 0, 3'd0, 0, 0, 0);
    chk("post_rst_ready", 32'(oReady), 32'd1);
    chk("post_rst_vec",   32'(oVec),   32'd0);

    // nominal N=2 timing table, row index = cycles after handshake cycle
    tbl[0] = mk(1, 3'd2, 1, 0, 0, 0);
    tbl[1] = mk(0, 3'd0, 0, 1, 1, 0);
    for (int i = 2; i <= 10; i++) tbl[i] = mk(0, 3'd0, 0, 1, 0, 0);
    tbl[5] = mk(0, 3'd0, 0, 1, 1, 0);
    tbl[11] = mk(0, 3'd0, 0, 0, 0, 1);
    tbl[12] = mk(0, 3'd0, 1, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      step(0, tbl[i].start, tbl[i].n, 0, 0, 0);
      chk($sformatf("nom%0d_ready", i), 32'(oReady), 32'(tbl[i].eReady));
      chk($sformatf("nom%0d_busy", i),  32'(oBusy),  32'(tbl[i].eBusy));
      chk($sformatf("nom%0d_begin", i), 32'(oBegin), 32'(tbl[i].eBegin));
      chk($sformatf("nom%0d_done", i),  32'(oDone),  32'(tbl[i].eDone));
    end
    idle(2);

    // stall: N=1, stall during T+3..T+5
    beginsInStall = 0; busyCnt = 0; doneAt = -1;
    for (int k = 0; k <= 12; k++) begin
      step(0, k == 0, 3'd1, (k >= 3 && k <= 5), 0, 0);
      if (k >= 3 && k <= 5 && oBegin) beginsInStall++;
      if (oBusy) busyCnt++;
      if (oDone && doneAt < 0) doneAt = k;
    end
    chk("stall_begins", 32'(beginsInStall), 32'd0);
    chk("stall_busy",   32'(busyCnt),       32'd9);
    chk("stall_done",   32'(doneAt),        32'd10);
    idle(2);

    // abort: N=4, abort at T+6, new N=1 request at T+7
    doneSeen = 0;
    for (int k = 0; k <= 7; k++) begin
      step(0, (k == 0) || (k == 7), (k == 7) ? 3'd1 : 3'd4, 0, k == 6, 0);
      if (oDone) doneSeen++;
      if (k == 7) begin
        chk("abort_busy",  32'(oBusy),  32'd0);
        chk("abort_ready", 32'(oReady), 32'd1);
        chk("abort_seq",   32'(oSeq),   32'd1);
      end
    end
    chk("abort_nodone", 32'(doneSeen), 32'd0);
    step(0, 0, 3'd0, 0, 0, 0);
    chk("abort_restart_busy", 32'(oBusy), 32'd1);
    idle(10);

    // clamp: N=0 then N=7
    busyCnt = 0;
    for (int k = 0; k <= 2; k++) begin
      step(0, k == 0, 3'd0, 0, 0, 0);
      if (oBusy) busyCnt++;
      if (k == 1) chk("n0_done", 32'(oDone), 32'd1);
    end
    chk("n0_busy", 32'(busyCnt), 32'd0);
    beginMask = 0; doneAt = -1;
    for (int k = 0; k <= 21; k++) begin
      step(0, k == 0, 3'd7, 0, 0, 0);
      if (oBegin) beginMask |= (1 << k);
      if (oDone && doneAt < 0) doneAt = k;
    end
    chk("n7_begins", 32'(beginMask), 32'h0000_2222);
    chk("n7_done",   32'(doneAt),    32'd19);

    // isGtr capture: 1,1,0,1 on begin cycles, toggling elsewhere
    for (int k = 0; k <= 20; k++) begin
      bit g;
      case (k)
        1, 5, 13: g = 1'b1;
        9:        g = 1'b0;
        default:  g = k[0];
      endcase
      step(0, k == 0, 3'd4, 0, 0, g);
    end
    chk("gtr_vec", 32'(oVec), 32'hb);
    chk("gtr_cnt", 32'(oCnt), 32'd3);
    for (int k = 0; k < 3; k++) step(0, 0, 3'd0, 0, 0, k[0]);
    chk("gtr_vec_hold", 32'(oVec), 32'hb);
    chk("gtr_cnt_hold", 32'(oCnt), 32'd3);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 30),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 2),
           1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
